// File: rtl/vc_mem_net_adapter.sv
// Bridges a client memory request/response port onto a request network and a response network.
// Net message = {dest, src, payload}; mem req = {type, addr, len, data}; mem resp = {type, len, data}.

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_) / 8) + (d_))
`endif

`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(a_, d_) (1 + $clog2((d_) / 8) + (d_))
`endif

`ifndef VC_NET_MSG_SZ
`define VC_NET_MSG_SZ(p_, s_) ((p_) + 2 * (s_))
`endif

module vc_mem_net_adapter #(
    parameter int p_num_nodes    = 4,
    parameter int p_addr_sz      = 8,
    parameter int p_data_sz      = 32,
    parameter int p_node_id      = 0,
    parameter int p_dest_lsb     = 0,
    parameter int p_max_inflight = 4,

    localparam int c_srcdest_sz      = $clog2(p_num_nodes),
    localparam int c_cnt_sz          = $clog2(p_max_inflight + 1),
    localparam int c_memreq_msg_sz   = `VC_MEM_REQ_MSG_SZ(p_addr_sz, p_data_sz),
    localparam int c_memresp_msg_sz  = `VC_MEM_RESP_MSG_SZ(p_addr_sz, p_data_sz),
    localparam int c_reqnet_msg_sz   = `VC_NET_MSG_SZ(c_memreq_msg_sz, c_srcdest_sz),
    localparam int c_respnet_msg_sz  = `VC_NET_MSG_SZ(c_memresp_msg_sz, c_srcdest_sz)
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [c_memreq_msg_sz-1:0]  memreq_msg,
    input  logic                        memreq_val,
    output logic                        memreq_rdy,

    output logic [c_reqnet_msg_sz-1:0]  netin_msg,
    output logic                        netin_val,
    input  logic                        netin_rdy,

    input  logic [c_respnet_msg_sz-1:0] netout_msg,
    input  logic                        netout_val,
    output logic                        netout_rdy,

    output logic [c_memresp_msg_sz-1:0] memresp_msg,
    output logic                        memresp_val,
    input  logic                        memresp_rdy,

    output logic [c_cnt_sz-1:0]         inflight_cnt,
    output logic                        err
);

    localparam int c_len_sz       = $clog2(p_data_sz / 8);
    localparam int c_req_addr_lsb = c_len_sz + p_data_sz;

    localparam logic [c_srcdest_sz-1:0] c_node_id  = c_srcdest_sz'(p_node_id);
    localparam logic [c_cnt_sz-1:0]     c_max_cnt  = c_cnt_sz'(p_max_inflight);
    localparam logic [c_cnt_sz-1:0]     c_cnt_one  = c_cnt_sz'(1);

    // ---------------------------------------------------------------
    // Message field helpers
    // ---------------------------------------------------------------

    function automatic logic [p_addr_sz-1:0] mem_req_addr(
        input logic [c_memreq_msg_sz-1:0] msg
    );
        return msg[c_req_addr_lsb +: p_addr_sz];
    endfunction

    function automatic logic [c_reqnet_msg_sz-1:0] net_req_to_bits(
        input logic [c_srcdest_sz-1:0]    dest,
        input logic [c_srcdest_sz-1:0]    src,
        input logic [c_memreq_msg_sz-1:0] payload
    );
        return {dest, src, payload};
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------

    logic [c_cnt_sz-1:0]     cnt_q,  cnt_d;
    logic [c_srcdest_sz-1:0] dest_q, dest_d;
    logic                    err_q,  err_d;

    // ---------------------------------------------------------------
    // Request path
    // ---------------------------------------------------------------

    logic [p_addr_sz-1:0]    req_addr;
    logic [c_srcdest_sz-1:0] req_dest;
    logic                    can_issue;
    logic                    req_fire;

    logic [c_srcdest_sz-1:0] resp_dest;
    logic [c_srcdest_sz-1:0] resp_src;
    logic                    resp_fire;
    logic                    resp_err;

    assign req_addr = mem_req_addr(memreq_msg);
    assign req_dest = req_addr[p_dest_lsb +: c_srcdest_sz];

    // Every outstanding request targets one node, so responses cannot reorder. A full
    // tracker still accepts when a response retires in the same cycle; the destination
    // switch waits on the registered count alone.
    assign can_issue = ((cnt_q == '0) || (req_dest == dest_q))
                    && ((cnt_q < c_max_cnt) || resp_fire);

    assign netin_msg  = net_req_to_bits(req_dest, c_node_id, memreq_msg);
    assign netin_val  = memreq_val && can_issue;
    assign memreq_rdy = netin_rdy && can_issue;
    assign req_fire   = netin_val && netin_rdy;

    // ---------------------------------------------------------------
    // Response path (zero latency pass-through)
    // ---------------------------------------------------------------

    assign resp_dest   = netout_msg[c_respnet_msg_sz-1 -: c_srcdest_sz];
    assign resp_src    = netout_msg[c_memresp_msg_sz +: c_srcdest_sz];
    assign memresp_msg = netout_msg[c_memresp_msg_sz-1:0];
    assign memresp_val = netout_val;
    assign netout_rdy  = memresp_rdy;
    assign resp_fire   = netout_val && netout_rdy;

    assign resp_err = (cnt_q == '0) || (resp_dest != c_node_id) || (resp_src != dest_q);

    // ---------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d  = cnt_q;
        dest_d = dest_q;
        err_d  = err_q;

        if (req_fire && !resp_fire) begin
            cnt_d = cnt_q + c_cnt_one;
        end else if (resp_fire && !req_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - c_cnt_one;
        end

        if (req_fire) begin
            dest_d = req_dest;
        end

        if (resp_fire && resp_err) begin
            err_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            dest_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dest_q <= dest_d;
            err_q  <= err_d;
        end
    end

    assign inflight_cnt = cnt_q;
    assign err          = err_q;

endmodule
